// File: rtl/sound_mixer_pkg.sv
// Shared types and constants for the multi-channel attenuating sound mixer.
// Gains reset to unity; board-specific attenuations are written at runtime.
package sound_mixer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_ACC,
        ST_SAT
    } mix_state_t;

    localparam int DEFAULT_MUL = 1;
    localparam int DEFAULT_DIV = 1;

    function automatic int calc_pw(input int in_width, input int mul_width);
        return in_width + mul_width;
    endfunction

    // One guard bit beyond the channel-count growth keeps the sum sign-safe.
    function automatic int calc_aw(input int pw, input int ch_count);
        return pw + $clog2(ch_count) + 1;
    endfunction

endpackage

// File: rtl/sound_mixer_att_serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, fixed N_WIDTH-cycle latency.
// done is high in the cycle whose clock edge completes the quotient; divide-by-zero yields 0.
module sound_mixer_att_serial_divider #(
    parameter int N_WIDTH = 14,
    parameter int D_WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [N_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic               done,
    output logic [N_WIDTH-1:0] quotient
);

    localparam int CNT_W = $clog2(N_WIDTH + 1);

    logic [CNT_W-1:0]   cnt;
    logic [D_WIDTH-1:0] rem;
    logic [D_WIDTH-1:0] dvs;
    logic [N_WIDTH-1:0] quo;
    logic               div_zero;
    logic [D_WIDTH:0]   trial;
    logic               fits;

    always_comb begin
        trial = {rem, quo[N_WIDTH-1]};
        fits  = (trial >= {1'b0, dvs});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            rem      <= '0;
            dvs      <= '0;
            quo      <= '0;
            div_zero <= 1'b0;
        end else if (start) begin
            cnt      <= CNT_W'(N_WIDTH);
            rem      <= '0;
            dvs      <= divisor;
            quo      <= dividend;
            div_zero <= (divisor == '0);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            rem <= fits ? D_WIDTH'(trial - {1'b0, dvs}) : trial[D_WIDTH-1:0];
            quo <= {quo[N_WIDTH-2:0], fits};
        end
    end

    assign done     = (cnt == CNT_W'(1));
    assign quotient = div_zero ? '0 : quo;

endmodule

// File: rtl/sound_mixer_att.sv
// Mixes CH_COUNT signed sources through per-channel MUL/DIV gains into one saturated sample,
// processing channels serially through one multiplier and one serial divider.
//
// state | meaning
// IDLE  | waiting for sample_req; inputs and gains captured on accept
// MUL   | product of current channel sample and gain numerator, divider started
// DIV   | serial divide of |product| by gain denominator
// ACC   | signed quotient added to accumulator, advance channel
// SAT   | clamp accumulator to output range, publish sample
module sound_mixer_att
    import sound_mixer_pkg::*;
#(
    parameter int CH_COUNT  = 4,
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 10,
    parameter int MUL_WIDTH = 4,
    parameter int DIV_WIDTH = 3,
    localparam int CH_W     = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_req,
    input  logic [CH_COUNT*IN_WIDTH-1:0] ch_data,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [MUL_WIDTH-1:0]         cfg_mul,
    input  logic [DIV_WIDTH-1:0]         cfg_div,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         clip,
    output logic                         overrun
);

    localparam int PW        = calc_pw(IN_WIDTH, MUL_WIDTH);
    localparam int AW        = calc_aw(PW, CH_COUNT);
    localparam int SAT_MAX_I = 2 ** (OUT_WIDTH - 1) - 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(SAT_MAX_I);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-SAT_MAX_I - 1);

    logic [MUL_WIDTH-1:0]         live_mul [CH_COUNT];
    logic [DIV_WIDTH-1:0]         live_div [CH_COUNT];
    logic [MUL_WIDTH-1:0]         shd_mul  [CH_COUNT];
    logic [DIV_WIDTH-1:0]         shd_div  [CH_COUNT];
    logic [CH_COUNT*IN_WIDTH-1:0] shd_data;

    mix_state_t              state;
    logic [CH_W-1:0]         ch;
    logic                    neg;
    logic signed [AW-1:0]    acc;
    logic signed [IN_WIDTH-1:0] sample;
    logic signed [PW-1:0]    prod;
    logic [PW-1:0]           prod_abs;
    logic [PW-1:0]           quotient;
    logic signed [PW-1:0]    q_signed;
    logic                    div_done;

    always_comb begin
        sample   = shd_data[ch*IN_WIDTH +: IN_WIDTH];
        prod     = PW'(sample) * $signed(PW'({1'b0, shd_mul[ch]}));
        prod_abs = prod[PW-1] ? $unsigned(-prod) : $unsigned(prod);
        q_signed = neg ? -$signed(quotient) : $signed(quotient);
    end

    sound_mixer_att_serial_divider #(
        .N_WIDTH(PW),
        .D_WIDTH(DIV_WIDTH)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (state == ST_MUL),
        .dividend (prod_abs),
        .divisor  (shd_div[ch]),
        .done     (div_done),
        .quotient (quotient)
    );

    // Live gains; indices beyond CH_COUNT-1 match no register and are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH_COUNT; i++) begin
                live_mul[i] <= MUL_WIDTH'(DEFAULT_MUL);
                live_div[i] <= DIV_WIDTH'(DEFAULT_DIV);
            end
        end else if (cfg_we) begin
            for (int i = 0; i < CH_COUNT; i++) begin
                if (cfg_ch == CH_W'(i)) begin
                    live_mul[i] <= cfg_mul;
                    live_div[i] <= cfg_div;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ch        <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            shd_data  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < CH_COUNT; i++) begin
                shd_mul[i] <= MUL_WIDTH'(DEFAULT_MUL);
                shd_div[i] <= DIV_WIDTH'(DEFAULT_DIV);
            end
        end else begin
            out_valid <= 1'b0;
            if (sample_req && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (sample_req) begin
                        shd_data <= ch_data;
                        shd_mul  <= live_mul;
                        shd_div  <= live_div;
                        acc      <= '0;
                        ch       <= '0;
                        busy     <= 1'b1;
                        state    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    neg   <= prod[PW-1];
                    state <= ST_DIV;
                end
                ST_DIV: begin
                    if (div_done) begin
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc <= acc + AW'(q_signed);
                    if (ch == CH_W'(CH_COUNT - 1)) begin
                        state <= ST_SAT;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= ST_MUL;
                    end
                end
                ST_SAT: begin
                    if (acc > SAT_MAX) begin
                        out_data <= {1'b0, {(OUT_WIDTH-1){1'b1}}};
                        clip     <= 1'b1;
                    end else if (acc < SAT_MIN) begin
                        out_data <= {1'b1, {(OUT_WIDTH-1){1'b0}}};
                        clip     <= 1'b1;
                    end else begin
                        out_data <= acc[OUT_WIDTH-1:0];
                        clip     <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_mixer_att.sv
// Directed bench for sound_mixer_att: latency, gain arithmetic, saturation, overrun, reset abort.
module tb_sound_mixer_att;

    localparam int CH    = 4;
    localparam int IN_W  = 10;
    localparam int OUT_W = 10;
    localparam int MUL_W = 4;
    localparam int DIV_W = 3;
    localparam int LAT   = 66;

    logic               clk;
    logic               reset_n;
    logic               sample_req;
    logic [CH*IN_W-1:0] ch_data;
    logic               cfg_we;
    logic [1:0]         cfg_ch;
    logic [MUL_W-1:0]   cfg_mul;
    logic [DIV_W-1:0]   cfg_div;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               busy;
    logic               clip;
    logic               overrun;

    int errors = 0;
    int checks = 0;

    sound_mixer_att #(
        .CH_COUNT (CH),
        .IN_WIDTH (IN_W),
        .OUT_WIDTH(OUT_W),
        .MUL_WIDTH(MUL_W),
        .DIV_WIDTH(DIV_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_req(sample_req),
        .ch_data   (ch_data),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mul   (cfg_mul),
        .cfg_div   (cfg_div),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .clip      (clip),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic set_gain(input int ch, input int m, input int d);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_mul = MUL_W'(m);
        cfg_div = DIV_W'(d);
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    task automatic set_ch(input int i, input int v);
        ch_data[i*IN_W +: IN_W] = IN_W'(v);
    endtask

    task automatic start_mix(output int cyc);
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        cyc = 1;
    endtask

    task automatic advance_to(inout int cyc, input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_valid(input int cyc_in, output int lat);
        int cyc;
        cyc = cyc_in;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        lat = (out_valid === 1'b1) ? cyc : -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL reset_clip: got %b want 0", clip); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_basic();
        int cyc, lat;
        set_ch(0, 100); set_ch(1, 0); set_ch(2, 0); set_ch(3, 0);
        set_gain(0, 9, 4);
        for (int i = 1; i < CH; i++) set_gain(i, 1, 0);
        start_mix(cyc);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
        wait_valid(cyc, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        checks++; if (out_data !== OUT_W'(225)) begin errors++; $display("FAIL basic_data: got %0d want 225", $signed(out_data)); end
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL basic_clip: got %b want 0", clip); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b want 0", out_valid); end
        checks++; if (out_data !== OUT_W'(225)) begin errors++; $display("FAIL basic_data_hold: got %0d want 225", $signed(out_data)); end
    endtask

    task automatic test_negative();
        int cyc, lat;
        set_ch(0, -101);
        start_mix(cyc);
        wait_valid(cyc, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL neg_latency: got %0d want %0d", lat, LAT); end
        checks++; if (out_data !== OUT_W'(-227)) begin errors++; $display("FAIL neg_data: got %0d want -227", $signed(out_data)); end
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL neg_clip: got %b want 0", clip); end
    endtask

    task automatic test_clip();
        int cyc, lat;
        for (int i = 0; i < CH; i++) begin
            set_gain(i, 15, 1);
            set_ch(i, 511);
        end
        start_mix(cyc);
        wait_valid(cyc, lat);
        checks++; if (out_data !== OUT_W'(511)) begin errors++; $display("FAIL clip_pos_data: got %0d want 511", $signed(out_data)); end
        checks++; if (clip !== 1'b1) begin errors++; $display("FAIL clip_pos_flag: got %b want 1", clip); end
        for (int i = 0; i < CH; i++) set_ch(i, -512);
        start_mix(cyc);
        wait_valid(cyc, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL clip_neg_latency: got %0d want %0d", lat, LAT); end
        checks++; if (out_data !== OUT_W'(-512)) begin errors++; $display("FAIL clip_neg_data: got %0d want -512", $signed(out_data)); end
        checks++; if (clip !== 1'b1) begin errors++; $display("FAIL clip_neg_flag: got %b want 1", clip); end
    endtask

    task automatic test_busy_write();
        int cyc, lat;
        set_gain(0, 9, 4);
        for (int i = 1; i < CH; i++) set_gain(i, 1, 0);
        set_ch(0, 100); set_ch(1, 0); set_ch(2, 0); set_ch(3, 0);
        start_mix(cyc);
        advance_to(cyc, 5);
        cfg_we  = 1'b1;
        cfg_ch  = 2'd0;
        cfg_mul = MUL_W'(1);
        cfg_div = DIV_W'(2);
        set_ch(0, 300);
        @(negedge clk);
        cyc++;
        cfg_we = 1'b0;
        wait_valid(cyc, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL busyw_latency: got %0d want %0d", lat, LAT); end
        checks++; if (out_data !== OUT_W'(225)) begin errors++; $display("FAIL busyw_old_gain: got %0d want 225", $signed(out_data)); end
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL busyw_clip_clear: got %b want 0", clip); end
        set_ch(0, 100);
        start_mix(cyc);
        wait_valid(cyc, lat);
        checks++; if (out_data !== OUT_W'(50)) begin errors++; $display("FAIL busyw_new_gain: got %0d want 50", $signed(out_data)); end
    endtask

    task automatic test_overrun();
        int cyc, lat, extra;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial: got %b want 0", overrun); end
        start_mix(cyc);
        advance_to(cyc, 10);
        sample_req = 1'b1;
        @(negedge clk);
        cyc++;
        sample_req = 1'b0;
        wait_valid(cyc, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL ovr_latency: got %0d want %0d", lat, LAT); end
        checks++; if (out_data !== OUT_W'(50)) begin errors++; $display("FAIL ovr_data: got %0d want 50", $signed(out_data)); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        extra = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL ovr_single_valid: got %0d extra pulses want 0", extra); end
        start_mix(cyc);
        wait_valid(cyc, lat);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_mix();
        int cyc, lat, seen;
        start_mix(cyc);
        advance_to(cyc, 30);
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rmid_out_data: got %0d want 0", $signed(out_data)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %b want 0", overrun); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_valid: got %0d pulses want 0", seen); end
        for (int i = 0; i < CH; i++) set_ch(i, 10);
        start_mix(cyc);
        wait_valid(cyc, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL rmid_latency: got %0d want %0d", lat, LAT); end
        checks++; if (out_data !== OUT_W'(40)) begin errors++; $display("FAIL rmid_unity_gain: got %0d want 40", $signed(out_data)); end
    endtask

    initial begin
        reset_n    = 1'b0;
        sample_req = 1'b0;
        ch_data    = '0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_mul    = '0;
        cfg_div    = '0;
        test_reset();
        test_basic();
        test_negative();
        test_clip();
        test_busy_write();
        test_overrun();
        test_reset_mid_mix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
